// File: rtl/decodificador_pwm.sv
// ----------------------------------------------------------------------------
// decodificador_pwm
//
// Measures the period and high time of an asynchronous fan PWM waveform and
// reduces the duty cycle to a 2-bit fan level. A watchdog on the period
// counter reports a stuck input as a "no signal" condition. In that case the
// level follows the static input value: 11 when it is stuck high, 00 when it
// is stuck low.
//
// Ports
//   clock      in   system clock, all state changes on its rising edge
//   reset      in   asynchronous active-low reset
//   pwm_in     in   asynchronous PWM waveform
//   s_nivel    out  [1:0] decoded level: 00 off, 01 low, 10 mid, 11 high
//   valido     out  s_nivel holds a measurement or a no-signal decision
//   pronto     out  one-cycle pulse whenever s_nivel/valido are updated
//   sem_sinal  out  no rising edge seen for TIMEOUT cycles
// ----------------------------------------------------------------------------
module decodificador_pwm #(
    parameter int TIMEOUT = 2000,
    parameter int PER_MIN = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       pwm_in,
    output logic [1:0] s_nivel,
    output logic       valido,
    output logic       pronto,
    output logic       sem_sinal
);

    localparam logic [15:0] LP_TIMEOUT = 16'(TIMEOUT);
    localparam logic [15:0] LP_PER_MIN = 16'(PER_MIN);

    typedef enum logic [1:0] {
        ESPERA    = 2'd0,
        MEDINDO   = 2'd1,
        SEM_SINAL = 2'd2
    } estado_t;

    estado_t     r_estado;
    estado_t     w_estado_nxt;

    logic        r_sync1;
    logic        r_sync2;
    logic        r_prev;
    logic [15:0] r_cnt_per;
    logic [15:0] r_cnt_alto;

    logic [1:0]  r_nivel;
    logic        r_valido;
    logic        r_pronto;
    logic        r_sem_sinal;

    logic [1:0]  w_nivel_nxt;
    logic        w_valido_nxt;
    logic        w_pronto_nxt;
    logic        w_sem_sinal_nxt;

    logic        w_sync;
    logic        w_rise;
    logic        w_glitch;
    logic        w_reload;
    logic        w_timeout;
    logic [1:0]  w_classe;
    logic [18:0] w_h8;
    logic [18:0] w_p1;
    logic [18:0] w_p3;
    logic [18:0] w_p5;

    assign w_sync = r_sync2;
    assign w_rise = r_sync2 & ~r_prev;

    // A too-short period is ignored entirely: the counters keep running so
    // the next real edge still measures the full period from the last good one.
    assign w_glitch = (r_estado == MEDINDO) && w_rise && (r_cnt_per < LP_PER_MIN);
    assign w_reload = w_rise && !w_glitch;

    // The edge wins over the watchdog. Excluding SEM_SINAL keeps a saturated
    // counter (TIMEOUT = 0xFFFF) from re-firing the timeout every cycle.
    assign w_timeout = (r_cnt_per == LP_TIMEOUT) && !w_rise && (r_estado != SEM_SINAL);

    // Duty classification by comparing 8*H with P, 3P and 5P (thresholds at
    // 1/8, 3/8 and 5/8). 19 bits hold 5 * 0xFFFF without overflow.
    always_comb begin
        w_h8 = {r_cnt_alto, 3'b000};
        w_p1 = {3'b000, r_cnt_per};
        w_p3 = w_p1 + (w_p1 << 1);
        w_p5 = w_p1 + (w_p1 << 2);
        if (w_h8 < w_p1) begin
            w_classe = 2'b00;
        end else if (w_h8 < w_p3) begin
            w_classe = 2'b01;
        end else if (w_h8 < w_p5) begin
            w_classe = 2'b10;
        end else begin
            w_classe = 2'b11;
        end
    end

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado <= ESPERA;
        end else begin
            r_estado <= w_estado_nxt;
        end
    end

    // Next-state logic
    // NOTE: every combinational output gets a default first, so that no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        w_estado_nxt = r_estado;
        case (r_estado)
            ESPERA: begin
                if (w_rise) begin
                    w_estado_nxt = MEDINDO;
                end else if (w_timeout) begin
                    w_estado_nxt = SEM_SINAL;
                end
            end
            MEDINDO: begin
                if (w_timeout) begin
                    w_estado_nxt = SEM_SINAL;
                end
            end
            SEM_SINAL: begin
                if (w_rise) begin
                    w_estado_nxt = ESPERA;
                end
            end
            default: w_estado_nxt = ESPERA;
        endcase
    end

    // Output logic: next values of the registered outputs
    always_comb begin
        w_nivel_nxt     = r_nivel;
        w_valido_nxt    = r_valido;
        w_sem_sinal_nxt = r_sem_sinal;
        w_pronto_nxt    = 1'b0;
        if (w_timeout) begin
            w_nivel_nxt     = w_sync ? 2'b11 : 2'b00;
            w_valido_nxt    = 1'b1;
            w_sem_sinal_nxt = 1'b1;
            w_pronto_nxt    = 1'b1;
        end else begin
            case (r_estado)
                MEDINDO: begin
                    if (w_rise && !w_glitch) begin
                        w_nivel_nxt  = w_classe;
                        w_valido_nxt = 1'b1;
                        w_pronto_nxt = 1'b1;
                    end
                end
                SEM_SINAL: begin
                    if (w_rise) begin
                        // Level and valido stay until a new measurement arrives.
                        w_sem_sinal_nxt = 1'b0;
                    end else if (w_sync != r_prev) begin
                        w_nivel_nxt  = w_sync ? 2'b11 : 2'b00;
                        w_pronto_nxt = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Synchronizer, measurement counters and output registers
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_prev      <= 1'b0;
            r_cnt_per   <= '0;
            r_cnt_alto  <= '0;
            r_nivel     <= 2'b00;
            r_valido    <= 1'b0;
            r_pronto    <= 1'b0;
            r_sem_sinal <= 1'b0;
        end else begin
            r_sync1 <= pwm_in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;

            // The counter values in the edge cycle are the captured P and H.
            if (w_reload) begin
                r_cnt_per <= 16'd1;
            end else if (r_cnt_per != 16'hFFFF) begin
                r_cnt_per <= r_cnt_per + 16'd1;
            end

            if (w_reload) begin
                r_cnt_alto <= 16'd1;
            end else if (w_sync && (r_cnt_alto != 16'hFFFF)) begin
                r_cnt_alto <= r_cnt_alto + 16'd1;
            end

            r_nivel     <= w_nivel_nxt;
            r_valido    <= w_valido_nxt;
            r_pronto    <= w_pronto_nxt;
            r_sem_sinal <= w_sem_sinal_nxt;
        end
    end

    assign s_nivel   = r_nivel;
    assign valido    = r_valido;
    assign pronto    = r_pronto;
    assign sem_sinal = r_sem_sinal;

endmodule

// File: tb/tb_decodificador_pwm.sv
// ----------------------------------------------------------------------------
// tb_decodificador_pwm
//
// Self-checking bench for decodificador_pwm. Every expected pronto is pushed
// to a scoreboard queue while the waveform is driven. A monitor pops the queue
// on each pronto and compares {s_nivel, valido, sem_sinal}. Level and flag
// checks between pulses are written directly in the stimulus.
// ----------------------------------------------------------------------------
module tb_decodificador_pwm;

    logic       clock;
    logic       reset;
    logic       pwm_in;
    logic [1:0] s_nivel;
    logic       valido;
    logic       pronto;
    logic       sem_sinal;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [1:0] nivel;
        logic       valido;
        logic       sem;
    } exp_t;

    typedef struct {
        int         high;
        int         low;
        logic [1:0] nivel;
    } vec_t;

    exp_t exp_q[$];
    vec_t tbl[7];
    logic prev_pronto = 1'b0;

    decodificador_pwm #(
        .TIMEOUT(2000),
        .PER_MIN(4)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .pwm_in   (pwm_in),
        .s_nivel  (s_nivel),
        .valido   (valido),
        .pronto   (pronto),
        .sem_sinal(sem_sinal)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_out(input string name, input logic [1:0] lvl, input logic v, input logic s);
        check(name, 32'({s_nivel, valido, sem_sinal}), 32'({lvl, v, s}));
    endtask

    task automatic push_exp(input logic [1:0] lvl, input logic v, input logic s);
        exp_t e;
        e.nivel  = lvl;
        e.valido = v;
        e.sem    = s;
        exp_q.push_back(e);
    endtask

    // Hold pwm_in at v for n rising edges; returns 1 time unit after the last edge.
    task automatic drive(input logic v, input int n);
        pwm_in = v;
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Scoreboard monitor, sampling on the falling edge.
    always @(negedge clock) begin
        if (pronto) begin
            check("pronto_gap", 32'(prev_pronto), 32'd0);
            if (exp_q.size() == 0) begin
                check("pronto_unexpected", 32'(pronto), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("pronto_outputs", 32'({s_nivel, valido, sem_sinal}), 32'(e));
            end
        end
        prev_pronto = pronto;
    end

    initial begin
        tbl[0] = '{high: 300, low: 700, nivel: 2'b01};
        tbl[1] = '{high: 300, low: 700, nivel: 2'b01};
        tbl[2] = '{high: 50,  low: 950, nivel: 2'b00};
        tbl[3] = '{high: 300, low: 700, nivel: 2'b01};
        tbl[4] = '{high: 550, low: 450, nivel: 2'b10};
        tbl[5] = '{high: 900, low: 100, nivel: 2'b11};
        tbl[6] = '{high: 500, low: 500, nivel: 2'b10};

        // Reset state
        reset  = 1'b0;
        pwm_in = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_nivel", 32'(s_nivel), 32'd0);
        check("rst_valido", 32'(valido), 32'd0);
        check("rst_pronto", 32'(pronto), 32'd0);
        check("rst_sem_sinal", 32'(sem_sinal), 32'd0);
        reset = 1'b1;

        // Input stuck low from reset: timeout exactly when cnt_per reaches 2000
        drive(1'b0, 2000);
        check("timeout_not_early", 32'(sem_sinal), 32'd0);
        push_exp(2'b00, 1'b1, 1'b1);
        drive(1'b0, 1);
        check_out("timeout_low", 2'b00, 1'b1, 1'b1);
        drive(1'b0, 499);
        drive(1'b1, 8);
        check_out("sem_sinal_exit", 2'b00, 1'b1, 1'b0);

        // Fresh reset before the measurement sweep
        pwm_in = 1'b0;
        reset  = 1'b0;
        drive(1'b0, 3);
        reset = 1'b1;
        drive(1'b0, 20);

        // Period 1000 sweep; each level shows up after the following rising edge
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 8);
            if (i == 0) begin
                check_out("first_edge_discard", 2'b00, 1'b0, 1'b0);
            end else begin
                check_out($sformatf("sweep_%0d", i - 1), tbl[i-1].nivel, 1'b1, 1'b0);
            end
            drive(1'b1, tbl[i].high - 8);
            drive(1'b0, tbl[i].low);
            push_exp(tbl[i].nivel, 1'b1, 1'b0);
        end

        // Glitch: 2-cycle period inside a steady 50% waveform
        drive(1'b1, 1);
        drive(1'b0, 1);
        drive(1'b1, 8);
        check_out("glitch_hold", 2'b10, 1'b1, 1'b0);
        drive(1'b1, 490);
        drive(1'b0, 500);
        push_exp(2'b10, 1'b1, 1'b0);

        // Input stuck high after a measurement
        push_exp(2'b11, 1'b1, 1'b1);
        drive(1'b1, 8);
        check_out("after_glitch", 2'b10, 1'b1, 1'b0);
        drive(1'b1, 2050);
        check_out("timeout_high", 2'b11, 1'b1, 1'b1);

        // Level change while in no-signal, then exit through ESPERA
        push_exp(2'b00, 1'b1, 1'b1);
        drive(1'b0, 20);
        check_out("sem_sinal_fall", 2'b00, 1'b1, 1'b1);
        drive(1'b1, 10);
        check_out("sem_sinal_exit2", 2'b00, 1'b1, 1'b0);
        drive(1'b1, 290);
        drive(1'b0, 700);
        drive(1'b1, 10);
        check_out("espera_discard", 2'b00, 1'b1, 1'b0);
        drive(1'b1, 290);
        drive(1'b0, 700);
        push_exp(2'b01, 1'b1, 1'b0);
        drive(1'b1, 10);
        check_out("measure_after_espera", 2'b01, 1'b1, 1'b0);

        // Asynchronous reset in the middle of a period (low phase)
        drive(1'b1, 290);
        drive(1'b0, 300);
        #3;
        reset = 1'b0;
        #1;
        check_out("rst_async", 2'b00, 1'b0, 1'b0);
        check("rst_async_pronto", 32'(pronto), 32'd0);
        repeat (3) @(posedge clock);
        #3;
        reset = 1'b1;
        drive(1'b0, 200);
        check_out("rst_release", 2'b00, 1'b0, 1'b0);
        drive(1'b1, 8);
        check_out("rst_first_edge", 2'b00, 1'b0, 1'b0);
        drive(1'b1, 292);
        drive(1'b0, 700);
        push_exp(2'b01, 1'b1, 1'b0);
        drive(1'b1, 8);
        check_out("rst_second_edge", 2'b01, 1'b1, 1'b0);
        drive(1'b0, 20);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
